systolic_deskew: RTL and testbench
==================================

Name: systolic_deskew

Overview:
- Output-side companion to the input skew delay lines of the systolic array.
- Takes the DIM staggered lane outputs (lane i lags lane 0 by i cycles) and realigns them into full rows.
- Buffers aligned rows in a small circular FIFO and hands them to the host side over valid/ready.
- Array cannot stall, so rows that arrive while the FIFO is full are dropped and flagged.

Parameters:
- DIM, 8, number of lanes (array columns); min 1.
- BITS, 64, width of one lane word.
- OUT_DEPTH, 4, aligned-row FIFO entries; power of 2, min 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  advance the delay lines this cycle
- in_data  in  DIM*BITS  lane i at [i*BITS +: BITS]
- in_valid  in  DIM  per-lane valid, same skew as in_data
- out_data  out  DIM*BITS  aligned row at FIFO head, lane i at [i*BITS +: BITS]
- out_valid  out  1  FIFO not empty
- out_ready  in  1  consumer accepts head row when out_valid=1
- full  out  1  FIFO holds OUT_DEPTH rows
- overflow  out  1  sticky: a complete row was dropped
- skew_err  out  1  sticky: lane valids disagreed after alignment
- clr_err  in  1  synchronous clear of overflow and skew_err

Behaviour:
- Reset (async assert): all delay-stage data and valids cleared. FIFO pointers and count cleared. Outputs on reset: out_valid=0, out_data=0, full=0, overflow=0, skew_err=0.
- Delay lines:
  - Lane i has DIM-1-i register stages for data and valid; lane DIM-1 has none and passes through combinationally.
  - Stages shift only on cycles with en=1; with en=0 they hold.
- Alignment point: aligned valid vector av = the delayed in_valid of every lane.
- Push, evaluated only when en=1:
  - All bits of av = 1: row is a push candidate.
  - av mixed (some bits 1, some 0): no push; skew_err <= 1.
  - All bits of av = 0: nothing happens.
- FIFO:
  - Circular buffer with write pointer, read pointer and count (0..OUT_DEPTH); pointers wrap modulo OUT_DEPTH.
  - Pop when out_valid and out_ready.
  - Push accepted if count<OUT_DEPTH or a pop occurs in the same cycle. Full with simultaneous push and pop: both happen, count unchanged, no overflow.
  - Push while full with no pop: row dropped; overflow <= 1; FIFO contents unchanged.
  - No empty-bypass; a pushed row is visible the cycle after the push edge.
  - out_data = entry at read pointer. out_valid = (count != 0). full = (count == OUT_DEPTH).
- Latency: with en held 1 and FIFO empty, a row whose lane-0 word is presented in cycle t is on out_data with out_valid=1 in cycle t+DIM. DIM=1 gives latency 1.
- Flag priority: clr_err clears both sticky flags unless a set condition occurs in the same cycle; set wins.
- Reset mid-operation: all partial rows in the delay lines are lost; nothing is re-emitted after reset.

Optional Feature:
- Macro: DESKEW_OCC_EN.
- Defined: extra output port occupancy, width $clog2(OUT_DEPTH+1), equal to the current FIFO count and updated at the same edge as count; reset value 0.
- Undefined: port absent; all other behaviour identical.

Test Plan (DIM=4, BITS=16, OUT_DEPTH=4, en=1 unless stated):
- Single row: lane i word 16'h0010+i presented with in_valid[i]=1 in cycle i (cycles 0..3), out_ready=1 -> cycle 4: out_valid=1, out_data=64'h0013_0012_0011_0010; cycle 5: out_valid=0.
- Overflow: six rows back-to-back (lane-0 words 1..6), out_ready=0 -> full=1 after row 4; rows 5 and 6 dropped; overflow=1. Then raise out_ready -> rows 1,2,3,4 in order on consecutive cycles, then out_valid=0. Pulse clr_err -> overflow=0.
- Skew error: row with in_valid[2]=0 and other lanes valid -> no row emitted; skew_err=1; a following good row is emitted normally.
- Stall: en=0 for 3 cycles immediately after lane 1 word presented -> row appears at cycle 7 instead of 4; data unchanged.
- Full with push and pop: FIFO holds 4 rows, out_ready=1 in the same cycle a new row aligns -> overflow stays 0, full stays 1. With DESKEW_OCC_EN, occupancy stays 4.
- Reset mid-row: assert rst_n=0 after lanes 0-1 presented -> out_valid=0, full=0, flags 0. After release, no stale row appears within 8 cycles.

Source files
------------

// File: rtl/systolic_deskew.sv
// Realigns DIM skewed lane outputs into rows (DIM-cycle latency) and queues them in a small FIFO.
// Rows that align into a full FIFO are dropped (array cannot stall). DESKEW_OCC_EN adds the occupancy output.
module systolic_deskew #(
  parameter int DIM       = 8,
  parameter int BITS      = 64,
  parameter int OUT_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [DIM*BITS-1:0] in_data,
  input  logic [DIM-1:0]      in_valid,
  output logic [DIM*BITS-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                full,
  output logic                overflow,
  output logic                skew_err,
  input  logic                clr_err
`ifdef DESKEW_OCC_EN
  ,
  output logic [$clog2(OUT_DEPTH+1)-1:0] occupancy
`endif
);

  localparam int PW = $clog2(OUT_DEPTH);
  localparam int CW = $clog2(OUT_DEPTH + 1);

  logic [DIM*BITS-1:0] al_data;
  logic [DIM-1:0]      av;

  // Lane g needs DIM-1-g stages so every lane lines up with the last one.
  for (genvar g = 0; g < DIM; g++) begin : g_lane
    localparam int ST = DIM - 1 - g;
    if (ST == 0) begin : g_pass
      assign al_data[g*BITS +: BITS] = in_data[g*BITS +: BITS];
      assign av[g]                   = in_valid[g];
    end else begin : g_dly
      logic [BITS-1:0] dat_q [ST];
      logic [ST-1:0]   vld_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int s = 0; s < ST; s++) dat_q[s] <= '0;
          vld_q <= '0;
        end else if (en) begin
          dat_q[0] <= in_data[g*BITS +: BITS];
          vld_q[0] <= in_valid[g];
          for (int s = 1; s < ST; s++) begin
            dat_q[s] <= dat_q[s-1];
            vld_q[s] <= vld_q[s-1];
          end
        end
      end

      assign al_data[g*BITS +: BITS] = dat_q[ST-1];
      assign av[g]                   = vld_q[ST-1];
    end
  end

  logic [DIM*BITS-1:0] mem_q [OUT_DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                overflow_q, overflow_d;
  logic                skew_err_q, skew_err_d;

  logic push_cand, mixed, pop, push, drop, is_full;

  always_comb begin
    push_cand  = en & (&av);
    mixed      = en & (|av) & ~(&av);
    is_full    = (cnt_q == CW'(OUT_DEPTH));
    pop        = (cnt_q != '0) & out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    push       = push_cand & (~is_full | pop);
    drop       = push_cand & is_full & ~pop;

    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    cnt_d      = cnt_q + CW'(push) - CW'(pop);

    overflow_d = overflow_q;
    if (clr_err) overflow_d = 1'b0;
    if (drop)    overflow_d = 1'b1;

    skew_err_d = skew_err_q;
    if (clr_err) skew_err_d = 1'b0;
    if (mixed)   skew_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      skew_err_q <= 1'b0;
      for (int k = 0; k < OUT_DEPTH; k++) mem_q[k] <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
      skew_err_q <= skew_err_d;
      if (push) mem_q[wr_ptr_q] <= al_data;
    end
  end

  assign out_data  = mem_q[rd_ptr_q];
  assign out_valid = (cnt_q != '0);
  assign full      = is_full;
  assign overflow  = overflow_q;
  assign skew_err  = skew_err_q;

`ifdef DESKEW_OCC_EN
  assign occupancy = cnt_q;
`endif

endmodule

// File: tb/tb_systolic_deskew.sv
// Bench for systolic_deskew at DIM=4, BITS=16, OUT_DEPTH=4: row table plus hand-written corner sequences.
module tb_systolic_deskew;

  localparam int DIM  = 4;
  localparam int BITS = 16;
  localparam int DEP  = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                en;
  logic [DIM*BITS-1:0] in_data;
  logic [DIM-1:0]      in_valid;
  logic [DIM*BITS-1:0] out_data;
  logic                out_valid;
  logic                out_ready;
  logic                full;
  logic                overflow;
  logic                skew_err;
  logic                clr_err;
`ifdef DESKEW_OCC_EN
  logic [2:0]          occupancy;
`endif

  systolic_deskew #(.DIM(DIM), .BITS(BITS), .OUT_DEPTH(DEP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .full      (full),
    .overflow  (overflow),
    .skew_err  (skew_err),
    .clr_err   (clr_err)
`ifdef DESKEW_OCC_EN
    ,
    .occupancy (occupancy)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  logic [15:0] row_base [16];
  logic [3:0]  row_vm   [16];

  typedef struct {
    logic [15:0] base;
    logic [3:0]  vmask;
    bit          emit;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mkrow(input logic [15:0] b);
    logic [63:0] r;
    for (int i = 0; i < DIM; i++) r[i*BITS +: BITS] = b + 16'(i);
    return r;
  endfunction

  // Presents n rows back-to-back with the lane skew; optionally pulses out_ready in one cycle.
  task automatic send_rows(input int n, input int rdy_at);
    for (int c = 0; c < n + DIM - 1; c++) begin
      @(posedge clk); #1;
      in_valid = '0;
      in_data  = '0;
      for (int i = 0; i < DIM; i++) begin
        int j;
        j = c - i;
        if (j >= 0 && j < n) begin
          in_data[i*BITS +: BITS] = row_base[j] + 16'(i);
          in_valid[i]             = row_vm[j][i];
        end
      end
      if (rdy_at >= 0) out_ready = (c == rdy_at);
    end
    @(posedge clk); #1;
    in_valid = '0;
    in_data  = '0;
    if (rdy_at >= 0) out_ready = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard: every handshake must match the oldest expected row.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_unexpected_row actual=%h expected=none", out_data);
      end else begin
        chk("mon_row", out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    tbl[0] = '{16'h0100, 4'hF,    1'b1};
    tbl[1] = '{16'h0200, 4'b1011, 1'b0};
    tbl[2] = '{16'h0300, 4'hF,    1'b1};
    tbl[3] = '{16'h0400, 4'h0,    1'b0};
    tbl[4] = '{16'h0500, 4'b0001, 1'b0};
    tbl[5] = '{16'h0600, 4'hF,    1'b1};

    rst_n = 1'b0; en = 1'b1; in_data = '0; in_valid = '0;
    out_ready = 1'b0; clr_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  out_data,       64'd0);
    chk("rst_full",      64'(full),      64'd0);
    chk("rst_overflow",  64'(overflow),  64'd0);
    chk("rst_skew_err",  64'(skew_err),  64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Single row latency: lane i presented in cycle i, row visible in cycle 4 only.
    exp_q.push_back(64'h0013_0012_0011_0010);
    for (int c = 0; c < DIM; c++) begin
      @(posedge clk); #1;
      in_valid = '0; in_data = '0;
      in_valid[c] = 1'b1;
      in_data[c*BITS +: BITS] = 16'h0010 + 16'(c);
      @(negedge clk);
      chk("single_not_early", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;
    in_valid = '0; in_data = '0;
    @(negedge clk);
    chk("single_vld_c4",  64'(out_valid), 64'd1);
    chk("single_data_c4", out_data,       64'h0013_0012_0011_0010);
    @(negedge clk);
    chk("single_vld_c5",  64'(out_valid), 64'd0);

    // Row table: good rows are queued, mixed rows raise skew_err, empty rows do nothing.
    for (int t = 0; t < 6; t++) begin
      row_base[t] = tbl[t].base;
      row_vm[t]   = tbl[t].vmask;
      if (tbl[t].emit) exp_q.push_back(mkrow(tbl[t].base));
    end
    send_rows(6, -1);
    wait_drain(20);
    @(negedge clk);
    chk("tbl_skew_err", 64'(skew_err), 64'd1);
    chk("tbl_overflow", 64'(overflow), 64'd0);
    @(posedge clk); #1; clr_err = 1'b1;
    @(posedge clk); #1; clr_err = 1'b0;
    @(negedge clk);
    chk("tbl_skew_clr", 64'(skew_err), 64'd0);

    // Overflow: six rows into a stalled consumer, rows 5 and 6 lost.
    out_ready = 1'b0;
    for (int t = 0; t < 6; t++) begin
      row_base[t] = 16'(t + 1);
      row_vm[t]   = 4'hF;
      if (t < DEP) exp_q.push_back(mkrow(16'(t + 1)));
    end
    send_rows(6, -1);
    @(negedge clk);
    chk("ovf_full",     64'(full),      64'd1);
    chk("ovf_overflow", 64'(overflow),  64'd1);
    chk("ovf_skew",     64'(skew_err),  64'd0);
    @(posedge clk); #1; out_ready = 1'b1;
    for (int i = 0; i < DEP; i++) begin
      @(negedge clk);
      chk("ovf_drain_vld", 64'(out_valid), 64'd1);
    end
    @(negedge clk);
    chk("ovf_drained_vld",  64'(out_valid), 64'd0);
    chk("ovf_drained_full", 64'(full),      64'd0);
    chk("ovf_queue_empty",  64'(exp_q.size()), 64'd0);
    @(posedge clk); #1; clr_err = 1'b1;
    @(posedge clk); #1; clr_err = 1'b0;
    @(negedge clk);
    chk("ovf_clr", 64'(overflow), 64'd0);

    // Full FIFO with a push and pop on the same edge.
    out_ready = 1'b0;
    for (int t = 0; t < 5; t++) begin
      row_base[t] = 16'h2000 + 16'(t * 16);
      row_vm[t]   = 4'hF;
      exp_q.push_back(mkrow(row_base[t]));
    end
    send_rows(5, 7);
    @(negedge clk);
    chk("pp_full",     64'(full),     64'd1);
    chk("pp_overflow", 64'(overflow), 64'd0);
`ifdef DESKEW_OCC_EN
    chk("pp_occupancy", 64'(occupancy), 64'd4);
`endif
    @(posedge clk); #1; out_ready = 1'b1;
    wait_drain(20);

    // Stall: en low for three cycles after lane 1 -> row appears in cycle 7.
    exp_q.push_back(mkrow(16'h0A00));
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      in_valid = '0; in_data = '0;
      en = !(c >= 2 && c <= 4);
      if (c < 2 || c > 4) begin
        int ln;
        ln = (c < 2) ? c : c - 3;
        in_valid[ln] = 1'b1;
        in_data[ln*BITS +: BITS] = 16'h0A00 + 16'(ln);
      end
      @(negedge clk);
      chk("stall_not_early", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;
    in_valid = '0; in_data = '0; en = 1'b1;
    @(negedge clk);
    chk("stall_vld_c7",  64'(out_valid), 64'd1);
    chk("stall_data_c7", out_data,       mkrow(16'h0A00));
    wait_drain(10);

    // Reset mid-row with a full FIFO: everything is lost.
    out_ready = 1'b0;
    for (int t = 0; t < DEP; t++) begin
      row_base[t] = 16'h3000 + 16'(t * 16);
      row_vm[t]   = 4'hF;
    end
    send_rows(DEP, -1);
    @(negedge clk);
    chk("rmid_pre_full", 64'(full), 64'd1);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      in_valid = '0; in_data = '0;
      in_valid[c] = 1'b1;
      in_data[c*BITS +: BITS] = 16'h4000 + 16'(c);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    in_valid = '0; in_data = '0;
    @(negedge clk);
    chk("rmid_vld",      64'(out_valid), 64'd0);
    chk("rmid_full",     64'(full),      64'd0);
    chk("rmid_overflow", 64'(overflow),  64'd0);
    chk("rmid_skew",     64'(skew_err),  64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("rmid_no_stale", 64'(out_valid), 64'd0);
    end
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
